// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: pops one weight set, holds the weight-reload strobe, streams a
// contiguous run of UB activation reads and writes the matching result vectors
// after the fixed pipeline latency.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        tile request (IDLE only) / cancel current tile
//   cfg_act_base        UB address of first activation vector
//   cfg_res_base        result SRAM address of first result vector
//   cfg_len             number of activation vectors in the tile
//   fifo_empty          weight FIFO empty flag
//   fifo_read_enable    weight FIFO pop
//   we_rl               systolic weight-reload strobe
//   ub_rd_en, ub_addr   UB read valid / address
//   res_we, res_addr    result SRAM write enable / address
//   busy, done          not-idle flag / one-cycle tile-complete pulse
module tpu_tile_sequencer #(
   parameter int unsigned ADDRESSSIZE  = 10,
   parameter int unsigned LEN_BW       = 8,
   parameter int unsigned WLOAD_CYCLES = 8,
   parameter int unsigned PIPE_LAT     = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDRESSSIZE-1:0] cfg_act_base,
   input  logic [ADDRESSSIZE-1:0] cfg_res_base,
   input  logic [LEN_BW-1:0]      cfg_len,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   we_rl,
   output logic                   ub_rd_en,
   output logic [ADDRESSSIZE-1:0] ub_addr,
   output logic                   res_we,
   output logic [ADDRESSSIZE-1:0] res_addr,
   output logic                   busy,
   output logic                   done
);

   // Counter must reach PIPE_LAT+len-1 in RUN and WLOAD_CYCLES-1 in WLOAD.
   localparam int unsigned RUN_MAX = PIPE_LAT + (1 << LEN_BW);
   localparam int unsigned CNT_MAX = (RUN_MAX > WLOAD_CYCLES) ? RUN_MAX : WLOAD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT_W = 3'd1;
   localparam logic [2:0] S_WLOAD  = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDRESSSIZE-1:0] act_base_q, act_base_d;
   logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;
   logic [LEN_BW-1:0]      len_q, len_d;

   logic [CNT_W-1:0] len_ext;
   logic [CNT_W-1:0] pipe_lat;
   logic [CNT_W-1:0] wload_last;
   logic [CNT_W-1:0] run_last;
   logic [CNT_W-1:0] res_idx;
   logic             ub_act;
   logic             res_act;

   assign len_ext    = CNT_W'(len_q);
   assign pipe_lat   = CNT_W'(PIPE_LAT);
   assign wload_last = CNT_W'(WLOAD_CYCLES - 1);
   assign run_last   = pipe_lat + len_ext - CNT_W'(1);
   assign res_idx    = cnt_q - pipe_lat;

   // State register, counter and latched tile configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         act_base_q <= '0;
         res_base_q <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         act_base_q <= act_base_d;
         res_base_q <= res_base_d;
         len_q      <= len_d;
      end
   end

   // Next-state logic; abort overrides every transition (and drops a same-cycle start).
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      act_base_d = act_base_q;
      res_base_d = res_base_q;
      len_d      = len_q;
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  act_base_d = cfg_act_base;
                  res_base_d = cfg_res_base;
                  len_d      = cfg_len;
                  cnt_d      = '0;
                  state_d    = S_WAIT_W;
               end
            end
            S_WAIT_W: begin
               if (!fifo_empty) begin
                  cnt_d   = '0;
                  state_d = S_WLOAD;
               end
            end
            S_WLOAD: begin
               if (cnt_q == wload_last) begin
                  cnt_d   = '0;
                  state_d = (len_q == '0) ? S_DONE : S_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (cnt_q == run_last) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
            default: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign ub_act  = (state_q == S_RUN) && (cnt_q < len_ext);
   assign res_act = (state_q == S_RUN) && (cnt_q >= pipe_lat) && (cnt_q < pipe_lat + len_ext);

   // Output decode; addresses are forced to 0 whenever their strobe is low.
   always_comb begin
      fifo_read_enable = 1'b0;
      we_rl            = 1'b0;
      ub_rd_en         = 1'b0;
      ub_addr          = '0;
      res_we           = 1'b0;
      res_addr         = '0;
      busy             = (state_q != S_IDLE);
      done             = (state_q == S_DONE);
      if (state_q == S_WAIT_W) fifo_read_enable = !fifo_empty;
      if (state_q == S_WLOAD)  we_rl = 1'b1;
      if (ub_act) begin
         ub_rd_en = 1'b1;
         ub_addr  = act_base_q + ADDRESSSIZE'(cnt_q);
      end
      if (res_act) begin
         res_we   = 1'b1;
         res_addr = res_base_q + ADDRESSSIZE'(res_idx);
      end
   end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: a timeline reference model (tile phases derived
// from the start and pop cycles) checked every cycle, directed scenarios with
// cycle-exact expectations, then randomized traffic.
module tb_tpu_tile_sequencer;

   localparam int W = 8;
   localparam int P = 24;

   logic       clk = 1'b0;
   logic       rst, start, abort, fifo_empty;
   logic [9:0] cfg_act_base, cfg_res_base;
   logic [7:0] cfg_len;
   logic       fifo_read_enable, we_rl, ub_rd_en, res_we, busy, done;
   logic [9:0] ub_addr, res_addr;

   tpu_tile_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_act_base(cfg_act_base), .cfg_res_base(cfg_res_base), .cfg_len(cfg_len),
      .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable), .we_rl(we_rl),
      .ub_rd_en(ub_rd_en), .ub_addr(ub_addr), .res_we(res_we), .res_addr(res_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int t0 = 0;

   // Reference model: 0 idle, 1 waiting for weights, 2 weights popped at m_tp.
   int         m_mode = 0;
   int         m_tp = 0;
   int         m_len = 0;
   logic [9:0] m_act = '0;
   logic [9:0] m_res = '0;

   // Per-scenario observation trackers (cycles relative to t0).
   int          tr_pop, tr_we, tr_we_n, tr_ub, tr_ub_n, tr_res, tr_res_n, tr_done, tr_done_n;
   logic [9:0]  tr_ub_a0, tr_ub_last, tr_res_a0, tr_res_last;
   logic [63:0] busy_hist;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
   endtask

   task automatic clr_trk();
      tr_pop = -1; tr_we = -1; tr_we_n = 0; tr_ub = -1; tr_ub_n = 0;
      tr_res = -1; tr_res_n = 0; tr_done = -1; tr_done_n = 0;
      tr_ub_a0 = '0; tr_ub_last = '0; tr_res_a0 = '0; tr_res_last = '0;
      busy_hist = '0;
   endtask

   // Drive one cycle of inputs, check all outputs against the model, advance.
   task automatic step(input bit r, input bit s, input bit a, input bit fe);
      logic       e_fre, e_we, e_ub, e_rw, e_busy, e_done;
      logic [9:0] e_ua, e_ra;
      int         rr, rel;
      rst = r; start = s; abort = a; fifo_empty = fe;
      #1;
      e_fre = 0; e_we = 0; e_ub = 0; e_rw = 0; e_busy = 0; e_done = 0;
      e_ua = '0; e_ra = '0;
      if (m_mode == 1) begin
         e_busy = 1;
         e_fre  = !fe;
      end else if (m_mode == 2) begin
         e_busy = 1;
         if (cyc <= m_tp + W) e_we = 1;
         else begin
            rr = cyc - (m_tp + W + 1);
            if (m_len == 0) e_done = (rr == 0);
            else begin
               if (rr < m_len) begin e_ub = 1; e_ua = 10'(m_act + rr); end
               if (rr >= P && rr < P + m_len) begin e_rw = 1; e_ra = 10'(m_res + rr - P); end
               if (rr == P + m_len) e_done = 1;
            end
         end
      end
      check("fifo_read_enable", 32'(fifo_read_enable), 32'(e_fre));
      check("we_rl",    32'(we_rl),    32'(e_we));
      check("ub_rd_en", 32'(ub_rd_en), 32'(e_ub));
      check("ub_addr",  32'(ub_addr),  32'(e_ua));
      check("res_we",   32'(res_we),   32'(e_rw));
      check("res_addr", 32'(res_addr), 32'(e_ra));
      check("busy",     32'(busy),     32'(e_busy));
      check("done",     32'(done),     32'(e_done));
      rel = cyc - t0;
      if (rel >= 0 && rel < 64) busy_hist[rel] = busy;
      if (fifo_read_enable) tr_pop = rel;
      if (we_rl) begin if (tr_we < 0) tr_we = rel; tr_we_n++; end
      if (ub_rd_en) begin
         if (tr_ub < 0) begin tr_ub = rel; tr_ub_a0 = ub_addr; end
         tr_ub_n++; tr_ub_last = ub_addr;
      end
      if (res_we) begin
         if (tr_res < 0) begin tr_res = rel; tr_res_a0 = res_addr; end
         tr_res_n++; tr_res_last = res_addr;
      end
      if (done) begin if (tr_done < 0) tr_done = rel; tr_done_n++; end
      if (r) m_mode = 0;
      else if (a) m_mode = 0;
      else if (m_mode == 0) begin
         if (s) begin
            m_mode = 1; m_act = cfg_act_base; m_res = cfg_res_base; m_len = int'(cfg_len);
         end
      end else if (m_mode == 1) begin
         if (!fe) begin m_mode = 2; m_tp = cyc; end
      end else if (e_done) m_mode = 0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One reset cycle, then a tile started at t0 with optional stall/abort/reset/extra starts.
   task automatic scen(input logic [9:0] act, input logic [9:0] res, input logic [7:0] len,
                       input int stall_to, input int abort_at, input int rst_at,
                       input int s1, input int s2, input int chg_at, input int ncyc);
      cfg_act_base = act; cfg_res_base = res; cfg_len = len;
      step(1, 0, 0, 0);
      t0 = cyc;
      clr_trk();
      for (int k = 0; k < ncyc; k++) begin
         if (k == chg_at) cfg_act_base = 10'h100;
         step(k == rst_at, k == 0 || k == s1 || k == s2, k == abort_at, k <= stall_to);
      end
   endtask

   initial begin
      rst = 1; start = 0; abort = 0; fifo_empty = 0;
      cfg_act_base = '0; cfg_res_base = '0; cfg_len = '0;
      @(posedge clk);
      #1;
      clr_trk();
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      // Basic tile.
      scen(10'h010, 10'h200, 8'd4, -1, -1, -1, -1, -1, -1, 45);
      check("basic_pop",       32'(tr_pop), 32'd1);
      check("basic_we_first",  32'(tr_we), 32'd2);
      check("basic_we_n",      32'(tr_we_n), 32'd8);
      check("basic_ub_first",  32'(tr_ub), 32'd10);
      check("basic_ub_n",      32'(tr_ub_n), 32'd4);
      check("basic_ub_last",   32'(tr_ub_last), 32'h013);
      check("basic_res_first", 32'(tr_res), 32'd34);
      check("basic_res_n",     32'(tr_res_n), 32'd4);
      check("basic_res_last",  32'(tr_res_last), 32'h203);
      check("basic_done",      32'(tr_done), 32'd38);
      check("basic_done_n",    32'(tr_done_n), 32'd1);
      check("basic_busy_0",    32'(busy_hist[0]), 32'd0);
      check("basic_busy_38",   32'(busy_hist[38]), 32'd1);
      check("basic_busy_39",   32'(busy_hist[39]), 32'd0);

      // FIFO stall through cycle 5.
      scen(10'h010, 10'h200, 8'd4, 5, -1, -1, -1, -1, -1, 50);
      check("stall_pop",      32'(tr_pop), 32'd6);
      check("stall_we_first", 32'(tr_we), 32'd7);
      check("stall_ub_first", 32'(tr_ub), 32'd15);
      check("stall_done",     32'(tr_done), 32'd43);

      // Address wrap.
      scen(10'h3FE, 10'h3FF, 8'd4, -1, -1, -1, -1, -1, -1, 45);
      check("wrap_ub_a0",    32'(tr_ub_a0), 32'h3FE);
      check("wrap_ub_last",  32'(tr_ub_last), 32'h001);
      check("wrap_res_a0",   32'(tr_res_a0), 32'h3FF);
      check("wrap_res_last", 32'(tr_res_last), 32'h002);

      // Zero-length tile.
      scen(10'h010, 10'h200, 8'd0, -1, -1, -1, -1, -1, -1, 15);
      check("len0_done",  32'(tr_done), 32'd10);
      check("len0_ub_n",  32'(tr_ub_n), 32'd0);
      check("len0_res_n", 32'(tr_res_n), 32'd0);

      // Config change + start while busy, then a new tile at cycle 39.
      scen(10'h010, 10'h200, 8'd4, -1, -1, -1, 12, 39, 12, 60);
      check("cfg_done",    32'(tr_done), 32'd38);
      check("cfg_done_n",  32'(tr_done_n), 32'd1);
      check("cfg_ub_n",    32'(tr_ub_n), 32'd8);
      check("cfg_ub_last", 32'(tr_ub_last), 32'h103);

      // Abort mid-run.
      scen(10'h010, 10'h200, 8'd4, -1, 20, -1, -1, -1, -1, 45);
      check("abort_busy_20", 32'(busy_hist[20]), 32'd1);
      check("abort_busy_21", 32'(busy_hist[21]), 32'd0);
      check("abort_res_n",   32'(tr_res_n), 32'd0);
      check("abort_done_n",  32'(tr_done_n), 32'd0);
      step(0, 1, 1, 0);
      check("abort_start_idle_busy", 32'(busy), 32'd0);
      step(0, 0, 0, 0);

      // Reset mid-operation, restart at 14.
      scen(10'h010, 10'h200, 8'd4, -1, -1, 12, 14, -1, -1, 30);
      check("rst_busy_12", 32'(busy_hist[12]), 32'd1);
      check("rst_busy_13", 32'(busy_hist[13]), 32'd0);
      check("rst_pop",     32'(tr_pop), 32'd15);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit r, s, a, fe;
         cfg_act_base = 10'($urandom);
         cfg_res_base = 10'($urandom);
         cfg_len = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         r  = ($urandom_range(0, 299) == 0);
         a  = ($urandom_range(0, 79) == 0);
         s  = ($urandom_range(0, 3) == 0);
         fe = ($urandom_range(0, 2) == 0);
         step(r, s, a, fe);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
Sequences one matrix tile through the TPU datapath. It pops one weight set from the weight FIFO and holds the systolic weight-reload strobe. It then streams a contiguous run of activation vectors out of the unified buffer. Finally it writes the matching result vectors into the result SRAM after the fixed pipeline latency. It sits between the host/top-level start logic and the UB, weight FIFO, systolic array and result SRAM, and replaces free-running counters as the address and write-enable source.

Parameters:
ADDRESSSIZE, 10, width of the UB and result SRAM addresses
LEN_BW, 8, width of the tile length (number of activation vectors)
WLOAD_CYCLES, 8, cycles we_rl is held high per weight load (= MATRIX_SIZE); must be ≥1
PIPE_LAT, 24, cycles from the first UB read to the first valid result word at the result SRAM input; must be ≥1

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to run a tile; sampled only in IDLE
abort  in  1  cancels the current tile
cfg_act_base  in  ADDRESSSIZE  UB address of the first activation vector
cfg_res_base  in  ADDRESSSIZE  result SRAM address of the first result vector
cfg_len  in  LEN_BW  number of activation vectors in the tile
fifo_empty  in  1  weight FIFO empty flag
fifo_read_enable  out  1  weight FIFO pop
we_rl  out  1  systolic array weight-reload strobe
ub_rd_en  out  1  activation address valid
ub_addr  out  ADDRESSSIZE  UB read address
res_we  out  1  result SRAM write enable
res_addr  out  ADDRESSSIZE  result SRAM write address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle tile-complete pulse

Behaviour:
- States are IDLE, WAIT_W, WLOAD, RUN and DONE. There is one state register and one counter cnt. cnt is wide enough for PIPE_LAT+2^LEN_BW.
- All outputs are combinational decodes of the state register, cnt and the latched config. Every output is 0 in IDLE and immediately after rst.
- rst: forces IDLE and cnt=0 and clears the latched config. Effective in any state, mid-tile included, with no done pulse.
- IDLE: on start=1 the block latches cfg_act_base, cfg_res_base and cfg_len and moves to WAIT_W. cfg_* changes after that point are ignored until the next IDLE.
- WAIT_W: fifo_read_enable = !fifo_empty.
  - If !fifo_empty, go to WLOAD with cnt=0.
  - If fifo_empty, stall indefinitely.
- WLOAD: we_rl=1.
  - cnt increments each cycle.
  - At cnt==WLOAD_CYCLES-1 the next state is RUN with cnt=0, or DONE if len==0.
- RUN: cnt increments each cycle.
  - ub_rd_en = (cnt < len); ub_addr = act_base + cnt, mod 2^ADDRESSSIZE.
  - res_we = (PIPE_LAT ≤ cnt < PIPE_LAT+len); res_addr = res_base + (cnt − PIPE_LAT), mod 2^ADDRESSSIZE.
  - At cnt==PIPE_LAT+len−1 the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is accepted again in the cycle after DONE.
- start while busy: ignored and not queued.
- abort=1 in any non-IDLE state: IDLE next cycle, no done pulse. A FIFO pop that already happened is not undone.
- abort and start in the same IDLE cycle: abort wins and the start is dropped.
- rst has priority over abort, and abort has priority over every other transition.
- When ub_rd_en is 0, ub_addr is 0. When res_we is 0, res_addr is 0.
- Total latency from start to done, with the FIFO non-empty and len>0: 1+1+WLOAD_CYCLES+PIPE_LAT+len cycles. With len==0 it is 2+WLOAD_CYCLES.

Test Plan:
- Basic tile: defaults, act_base=0x010, res_base=0x200, len=4, fifo_empty=0, start at cycle 0.
  - fifo_read_enable at cycle 1 only.
  - we_rl cycles 2–9.
  - ub_rd_en cycles 10–13 with ub_addr 0x010–0x013.
  - res_we cycles 34–37 with res_addr 0x200–0x203.
  - done at cycle 38 only, busy cycles 1–38.
- FIFO stall: same config with fifo_empty=1 through cycle 5, then 0.
  - fifo_read_enable only at cycle 6.
  - we_rl cycles 7–14.
  - done at cycle 43.
  - No UB reads before cycle 15.
- Wrap and length 0:
  - act_base=0x3FE, len=4 gives ub_addr 0x3FE, 0x3FF, 0x000, 0x001.
  - res_base=0x3FF gives res_addr 0x3FF, 0x000, 0x001, 0x002.
  - len=0 gives done at cycle 10 with no ub_rd_en and no res_we.
- Config latching and start-while-busy: change cfg_act_base to 0x100 and pulse start at cycle 12 of the basic tile.
  - Addresses stay 0x012, 0x013.
  - Exactly one done, at cycle 38.
  - A start at cycle 39 begins a new tile using 0x100.
- Abort: abort=1 at cycle 20 of the basic tile.
  - busy=0 from cycle 21.
  - No res_we and no done.
  - abort together with start in IDLE leaves busy=0.
- Reset mid-operation: rst=1 at cycle 12.
  - All outputs 0 from cycle 13.
  - A start at cycle 14 gives fifo_read_enable at cycle 15.
